// File: rtl/fp_pkg.sv
// Shared floating-point definitions: operand classes, flag bit positions
// and format-dependent constants for the pipelined multiplier.
package fp_pkg;

    typedef enum logic [2:0] {
        ZERO,
        NORM,
        INF,
        QNAN,
        SNAN
    } fp_class_e;

    localparam int FLG_NAN = 6;
    localparam int FLG_INF = 5;
    localparam int FLG_ZERO = 4;
    localparam int FLG_OVF = 3;
    localparam int FLG_UNF = 2;
    localparam int FLG_INV = 1;
    localparam int FLG_INX = 0;

    // Exponent bias; a format with no stored mantissa has no bias.
    function automatic int fp_bias(input int exp_w, input int man_w);
        return (man_w > 0) ? (1 << (exp_w - 1)) - 1 : 0;
    endfunction

    // Canonical quiet NaN: sign 0, exponent all-ones, mantissa MSB only.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

    // Positive infinity: exponent all-ones, mantissa zero.
    function automatic logic [63:0] fp_inf(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: zero (incl. flushed subnormals),
// normal, infinity, quiet NaN or signalling NaN.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic [EXP_W-1:0] i_exp,
    input  logic [MAN_W-1:0] i_mant,
    output fp_class_e        o_cls
);

    // Decode the exponent/mantissa fields into a single class.
    always_comb begin
        o_cls = NORM;
        if (i_exp == '0) begin
            o_cls = ZERO;
        end else if (&i_exp) begin
            if (i_mant == '0) begin
                o_cls = INF;
            end else if (i_mant[MAN_W-1]) begin
                o_cls = QNAN;
            end else begin
                o_cls = SNAN;
            end
        end
    end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready flow.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise truncates.
module fp_mul_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   num1,
    input  logic [EXP_W+MAN_W:0]   num2,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [6:0]             flags
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int EW = EXP_W + 2;

    localparam logic signed [EW-1:0] BIAS_C = EW'(fp_bias(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] EMAX_C = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_C = EW'(1);
    localparam logic signed [EW-1:0] EZERO_C = '0;
    localparam logic [W-1:0] QNAN_C = W'(fp_qnan(EXP_W, MAN_W));
    localparam logic [W-1:0] INF_C = W'(fp_inf(EXP_W, MAN_W));

    logic w_adv;

    fp_class_e w_cls1;
    fp_class_e w_cls2;
    logic signed [EW-1:0] w_exp_sum;
    logic [PW-1:0] w_prod;

    logic r1_valid;
    logic r1_sign;
    fp_class_e r1_cls1;
    fp_class_e r1_cls2;
    logic signed [EW-1:0] r1_exp;
    logic [PW-1:0] r1_prod;

    logic [MAN_W-1:0] w_mant;
    logic w_guard;
    logic w_sticky;
    logic signed [EW-1:0] w_exp_n;
    logic w_rup;
    logic [MAN_W:0] w_mant_r;
    logic signed [EW-1:0] w_exp_r;

    logic r2_valid;
    logic r2_sign;
    fp_class_e r2_cls1;
    fp_class_e r2_cls2;
    logic signed [EW-1:0] r2_exp;
    logic [MAN_W-1:0] r2_mant;
    logic r2_inexact;

    logic w_any_nan;
    logic w_any_snan;
    logic w_inf_zero;
    logic w_any_inf;
    logic w_any_zero;
    logic [W-1:0] w_res;
    logic [6:0] w_flg;

    logic r_out_valid;
    logic [W-1:0] r_result;
    logic [6:0] r_flags;

    assign w_adv = !r_out_valid || out_ready;
    assign in_ready = w_adv || rst;
    assign out_valid = r_out_valid;
    assign result = r_result;
    assign flags = r_flags;

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls1 (
        .i_exp  (num1[MAN_W +: EXP_W]),
        .i_mant (num1[MAN_W-1:0]),
        .o_cls  (w_cls1)
    );

    fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls2 (
        .i_exp  (num2[MAN_W +: EXP_W]),
        .i_mant (num2[MAN_W-1:0]),
        .o_cls  (w_cls2)
    );

    assign w_exp_sum = $signed({2'b00, num1[MAN_W +: EXP_W]})
                     + $signed({2'b00, num2[MAN_W +: EXP_W]})
                     - BIAS_C;
    assign w_prod = PW'({1'b1, num1[MAN_W-1:0]})
                  * PW'({1'b1, num2[MAN_W-1:0]});

    // S1: capture classes, exponent sum and raw significand product.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid <= 1'b0;
        end else if (w_adv) begin
            r1_valid <= in_valid;
            r1_sign <= num1[W-1] ^ num2[W-1];
            r1_cls1 <= w_cls1;
            r1_cls2 <= w_cls2;
            r1_exp <= w_exp_sum;
            r1_prod <= w_prod;
        end
    end

    // Normalise: pick kept bits, guard and sticky from the product.
    always_comb begin
        w_mant = '0;
        w_guard = 1'b0;
        w_sticky = 1'b0;
        w_exp_n = r1_exp;
        if (r1_prod[PW-1]) begin
            w_mant = r1_prod[PW-2 -: MAN_W];
            w_guard = r1_prod[MAN_W];
            w_sticky = |r1_prod[MAN_W-1:0];
            w_exp_n = r1_exp + ONE_C;
        end else begin
            w_mant = r1_prod[PW-3 -: MAN_W];
            w_guard = r1_prod[MAN_W-1];
            w_sticky = |r1_prod[MAN_W-2:0];
        end
    end

`ifdef FP_MUL_RNE_EN
    assign w_rup = w_guard & (w_sticky | w_mant[0]);
`else
    assign w_rup = 1'b0;
`endif

    // A rounding carry leaves the mantissa at zero and bumps the exponent.
    assign w_mant_r = {1'b0, w_mant} + {{MAN_W{1'b0}}, w_rup};
    assign w_exp_r = w_mant_r[MAN_W] ? w_exp_n + ONE_C : w_exp_n;

    // S2: register the normalised, rounded value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r2_valid <= 1'b0;
        end else if (w_adv) begin
            r2_valid <= r1_valid;
            r2_sign <= r1_sign;
            r2_cls1 <= r1_cls1;
            r2_cls2 <= r1_cls2;
            r2_exp <= w_exp_r;
            r2_mant <= w_mant_r[MAN_W-1:0];
            r2_inexact <= w_guard | w_sticky;
        end
    end

    assign w_any_nan = (r2_cls1 == QNAN) || (r2_cls1 == SNAN)
                    || (r2_cls2 == QNAN) || (r2_cls2 == SNAN);
    assign w_any_snan = (r2_cls1 == SNAN) || (r2_cls2 == SNAN);
    assign w_inf_zero = ((r2_cls1 == INF) && (r2_cls2 == ZERO))
                     || ((r2_cls1 == ZERO) && (r2_cls2 == INF));
    assign w_any_inf = (r2_cls1 == INF) || (r2_cls2 == INF);
    assign w_any_zero = (r2_cls1 == ZERO) || (r2_cls2 == ZERO);

    // Special values take priority over range checks on the normal path.
    always_comb begin
        w_res = '0;
        w_flg = '0;
        if (w_any_nan || w_inf_zero) begin
            w_res = QNAN_C;
            w_flg[FLG_NAN] = 1'b1;
            w_flg[FLG_INV] = w_any_snan || w_inf_zero;
        end else if (w_any_inf) begin
            w_res = INF_C | {r2_sign, {(W-1){1'b0}}};
            w_flg[FLG_INF] = 1'b1;
        end else if (w_any_zero) begin
            w_res = {r2_sign, {(W-1){1'b0}}};
            w_flg[FLG_ZERO] = 1'b1;
        end else if (r2_exp >= EMAX_C) begin
            w_res = INF_C | {r2_sign, {(W-1){1'b0}}};
            w_flg[FLG_OVF] = 1'b1;
            w_flg[FLG_INF] = 1'b1;
            w_flg[FLG_INX] = 1'b1;
        end else if (r2_exp <= EZERO_C) begin
            w_res = {r2_sign, {(W-1){1'b0}}};
            w_flg[FLG_UNF] = 1'b1;
            w_flg[FLG_ZERO] = 1'b1;
            w_flg[FLG_INX] = 1'b1;
        end else begin
            w_res = {r2_sign, r2_exp[EXP_W-1:0], r2_mant};
            w_flg[FLG_INX] = r2_inexact;
        end
    end

    // S3: output registers; flags read zero whenever no result is valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result <= '0;
            r_flags <= '0;
        end else if (w_adv) begin
            r_out_valid <= r2_valid;
            r_result <= r2_valid ? w_res : '0;
            r_flags <= r2_valid ? w_flg : '0;
        end
    end

endmodule
